// File: rtl/clz_norm.sv
// clz_norm: pipelined leading-zero / redundant-sign counter and normaliser.
//   MODE 0 counts leading zeros, MODE 1 counts redundant sign bits. Each result
//   carries the count, the input shifted left by that count, a degenerate-word
//   flag and the caller's tag. The pipeline has STAGES register slots with full
//   valid/ready backpressure and bubble collapse. STAGES = 0 is purely
//   combinational.
// Ports:
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake (in_ready may follow out_ready combinationally)
//   in_data [W], in_tag [TW]            word to analyse, opaque sideband
//   out_valid / out_ready               output handshake
//   out_count [CW], out_data [W], out_zero, out_tag [TW]   result of one word
module clz_norm #(
  parameter int unsigned W      = 32,
  parameter int unsigned MODE   = 0,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TW     = 4,
  localparam int unsigned CW    = $clog2(W + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic [W-1:0]  out_data,
  output logic          out_zero,
  output logic [TW-1:0] out_tag
);

  // The width is padded up to a power of two so the count tree halves evenly.
  localparam int unsigned LP = $clog2(W);
  localparam int unsigned P  = 1 << LP;

  typedef struct packed {
    logic [CW-1:0] count;
    logic [W-1:0]  data;
    logic          zero;
    logic [TW-1:0] tag;
  } payload_t;

  // Recursive halving: at each level test whether the upper half of the
  // remaining window is all zero; if so record the bit and shift it away.
  function automatic logic [LP:0] lead_count(input logic [P-1:0] v);
    logic [P-1:0] x;
    logic [P-1:0] mask;
    logic [LP:0]  n;
    x = v;
    n = '0;
    if (v == '0) begin
      n = (LP + 1)'(P);
    end else begin
      for (int l = int'(LP) - 1; l >= 0; l--) begin
        mask = ~({P{1'b1}} >> (1 << l));
        if ((x & mask) == '0) begin
          n[l] = 1'b1;
          x    = x << (1 << l);
        end
      end
    end
    return n;
  endfunction

  // Count and normalise the incoming word.
  logic [W-1:0]  t_c;
  logic [P-1:0]  padded_c;
  logic [LP:0]   raw_c;
  logic [LP:0]   clamp_c;
  logic [CW-1:0] cnt_c;
  payload_t      in_pl_c;

  always_comb begin
    // In sign mode, folding with the MSB turns the sign run into a zero run;
    // the inverted-MSB pad bits then become ones, same as in zero mode.
    t_c = (MODE == 1 && in_data[W-1]) ? ~in_data : in_data;
    padded_c = '1;
    padded_c[P-1 -: W] = t_c;
    raw_c   = lead_count(padded_c);
    clamp_c = (32'(raw_c) > W) ? (LP + 1)'(W) : raw_c;
    // The sign run always includes the MSB itself, so one bit is not redundant.
    cnt_c   = (MODE == 1) ? CW'(clamp_c - (LP + 1)'(1)) : CW'(clamp_c);
    in_pl_c.count = cnt_c;
    in_pl_c.data  = in_data << cnt_c;
    in_pl_c.zero  = (MODE == 1) ? (t_c == '0) : (in_data == '0);
    in_pl_c.tag   = in_tag;
  end

  generate
    if (STAGES == 0) begin : g_comb
      // Pass-through: results are combinational; outputs forced low in reset.
      assign in_ready  = out_ready;
      assign out_valid = in_valid & reset_n;
      assign out_count = reset_n ? in_pl_c.count : '0;
      assign out_data  = reset_n ? in_pl_c.data  : '0;
      assign out_zero  = reset_n & in_pl_c.zero;
      assign out_tag   = reset_n ? in_pl_c.tag   : '0;
    end else begin : g_pipe
      logic [STAGES-1:0] v;
      logic [STAGES-1:0] vin;
      logic [STAGES-1:0] adv;
      logic [STAGES-1:0] rdy;
      payload_t          pl  [STAGES];
      payload_t          pin [STAGES];

      // adv[k]: slot k's contents leave this cycle. rdy[k]: slot k can load.
      always_comb begin
        logic a;
        for (int k = 0; k < int'(STAGES); k++) begin
          a = out_ready;
          for (int j = k + 1; j < int'(STAGES); j++) begin
            a = a | ~v[j];
          end
          adv[k] = a;
          rdy[k] = ~v[k] | a;
        end
      end

      // Each slot loads from its upstream neighbour (slot 0 from the input).
      always_comb begin
        vin[0] = in_valid;
        pin[0] = in_pl_c;
        for (int k = 1; k < int'(STAGES); k++) begin
          vin[k] = v[k-1];
          pin[k] = pl[k-1];
        end
      end

      // Slot registers; payload only loads when a valid word arrives.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          v <= '0;
          for (int k = 0; k < int'(STAGES); k++) begin
            pl[k] <= '0;
          end
        end else begin
          for (int k = 0; k < int'(STAGES); k++) begin
            if (rdy[k]) begin
              v[k] <= vin[k];
              if (vin[k]) begin
                pl[k] <= pin[k];
              end
            end
          end
        end
      end

      assign in_ready  = rdy[0];
      assign out_valid = v[STAGES-1];
      assign out_count = pl[STAGES-1].count;
      assign out_data  = pl[STAGES-1].data;
      assign out_zero  = pl[STAGES-1].zero;
      assign out_tag   = pl[STAGES-1].tag;
    end
  endgenerate

endmodule

// File: tb/tb_clz_norm.sv
// tb_clz_norm: directed and randomised checks of clz_norm.
//   dut a: W=32 MODE 0 STAGES 2; dut b: W=24 MODE 1 STAGES 3; dut c: W=5 MODE 1 STAGES 0.
module tb_clz_norm;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          cnt;
    logic [31:0] data;
    logic        z;
    logic [3:0]  tag;
  } exp_t;

  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_out_zero;
  logic [31:0] a_in_data = '0, a_out_data;
  logic [3:0]  a_in_tag = '0, a_out_tag;
  logic [5:0]  a_out_count;

  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_out_zero;
  logic [23:0] b_in_data = '0, b_out_data;
  logic [3:0]  b_in_tag = '0, b_out_tag;
  logic [4:0]  b_out_count;

  logic c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_out_zero;
  logic [4:0]  c_in_data = '0, c_out_data;
  logic [3:0]  c_in_tag = '0, c_out_tag;
  logic [2:0]  c_out_count;

  clz_norm #(.W(32), .MODE(0), .STAGES(2), .TW(4)) u_a (
    .clock(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_count(a_out_count), .out_data(a_out_data), .out_zero(a_out_zero), .out_tag(a_out_tag));

  clz_norm #(.W(24), .MODE(1), .STAGES(3), .TW(4)) u_b (
    .clock(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_count(b_out_count), .out_data(b_out_data), .out_zero(b_out_zero), .out_tag(b_out_tag));

  clz_norm #(.W(5), .MODE(1), .STAGES(0), .TW(4)) u_c (
    .clock(clk), .reset_n(reset_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_tag(c_in_tag), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_count(c_out_count), .out_data(c_out_data), .out_zero(c_out_zero), .out_tag(c_out_tag));

  // Reference: walk bits from the MSB counting the leading run.
  function automatic void model(input logic [31:0] d, input int w, input int mode,
                                output exp_t e);
    logic [31:0] dd;
    logic [31:0] mask;
    logic        msb;
    logic        stop;
    int          run;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    dd   = d & mask;
    msb  = dd[w-1];
    run  = 0;
    stop = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      if (!stop && dd[i] == ((mode == 1) ? msb : 1'b0)) run++;
      else stop = 1'b1;
    end
    e.cnt  = (mode == 1) ? run - 1 : run;
    e.data = (dd << e.cnt) & mask;
    e.z    = (run == w);
    e.tag  = '0;
  endfunction

  function automatic logic [31:0] pick_word();
    logic [31:0] w;
    w = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) w = ~w;
    return w;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({a_out_valid, a_out_count, a_out_data, a_out_zero, a_out_tag} !== '0 ||
        b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: a v=%b cnt=%0d d=%h z=%b t=%h b v=%b c v=%b, want all zero",
               a_out_valid, a_out_count, a_out_data, a_out_zero, a_out_tag, b_out_valid, c_out_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: a=%b b=%b, want 1 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] din  [3] = '{32'h0001_0000, 32'h0000_0000, 32'h8000_0000};
    logic [31:0] dexp [3] = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
    int          cexp [3] = '{15, 32, 0};
    logic        zexp [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in_data   = din[i];
      a_in_tag    = 4'(3 + i);
      #1;
      n_tests++;
      if (a_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_ready[%0d]: got %b want 1", i, a_in_ready);
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      #1;
      n_tests++;
      if (a_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: out_valid %b after 1 cycle, want 0", i, a_out_valid);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (a_out_valid !== 1'b1 || 32'(a_out_count) !== cexp[i] || a_out_data !== dexp[i] ||
          a_out_zero !== zexp[i] || a_out_tag !== 4'(3 + i)) begin
        n_fail++;
        $display("FAIL basic[%0d]: got v=%b cnt=%0d d=%h z=%b t=%0d want v=1 cnt=%0d d=%h z=%b t=%0d",
                 i, a_out_valid, a_out_count, a_out_data, a_out_zero, a_out_tag,
                 cexp[i], dexp[i], zexp[i], 3 + i);
      end
    end
  endtask

  task automatic test_s0();
    logic [4:0] din  [3] = '{5'b00011, 5'b10000, 5'b11111};
    logic [4:0] dexp [3] = '{5'b01100, 5'b10000, 5'b10000};
    int         cexp [3] = '{2, 0, 4};
    logic       zexp [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      c_out_ready = 1'b1;
      c_in_valid  = 1'b1;
      c_in_data   = din[i];
      c_in_tag    = 4'(i + 5);
      #1;
      n_tests++;
      if (c_in_ready !== 1'b1 || c_out_valid !== 1'b1 || 32'(c_out_count) !== cexp[i] ||
          c_out_data !== dexp[i] || c_out_zero !== zexp[i] || c_out_tag !== 4'(i + 5)) begin
        n_fail++;
        $display("FAIL s0[%0d]: got r=%b v=%b cnt=%0d d=%b z=%b t=%0d want r=1 v=1 cnt=%0d d=%b z=%b t=%0d",
                 i, c_in_ready, c_out_valid, c_out_count, c_out_data, c_out_zero, c_out_tag,
                 cexp[i], dexp[i], zexp[i], i + 5);
      end
    end
    c_out_ready = 1'b0;
    #1;
    n_tests++;
    if (c_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL s0_ready_follow: got %b want 0", c_in_ready);
    end
    @(negedge clk);
    c_in_valid = 1'b0;
  endtask

  task automatic test_mode1();
    logic [23:0] din  [3] = '{24'hFFF000, 24'hFFFFFF, 24'h000001};
    logic [23:0] dexp [3] = '{24'h800000, 24'h800000, 24'h400000};
    int          cexp [3] = '{11, 23, 22};
    logic        zexp [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_out_ready = 1'b1;
      b_in_valid  = 1'b1;
      b_in_data   = din[i];
      b_in_tag    = 4'(i + 1);
      @(negedge clk);
      b_in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_tests++;
      if (b_out_valid !== 1'b1 || 32'(b_out_count) !== cexp[i] || b_out_data !== dexp[i] ||
          b_out_zero !== zexp[i] || b_out_tag !== 4'(i + 1)) begin
        n_fail++;
        $display("FAIL mode1[%0d]: got v=%b cnt=%0d d=%h z=%b t=%0d want v=1 cnt=%0d d=%h z=%b t=%0d",
                 i, b_out_valid, b_out_count, b_out_data, b_out_zero, b_out_tag,
                 cexp[i], dexp[i], zexp[i], i + 1);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int next_tag = 1;
    int exp_tag  = 1;
    logic saw_block = 1'b0;
    for (int cyc = 1; cyc <= 30 && exp_tag <= 6; cyc++) begin
      @(negedge clk);
      a_out_ready = !(cyc >= 3 && cyc <= 6);
      a_in_valid  = (next_tag <= 6);
      a_in_data   = 32'd1 << (next_tag + 3);
      a_in_tag    = 4'(next_tag);
      #1;
      if (a_in_valid && !a_in_ready) saw_block = 1'b1;
      if (a_out_valid && a_out_ready) begin
        n_tests++;
        if (a_out_tag !== 4'(exp_tag) || 32'(a_out_count) !== 28 - exp_tag ||
            a_out_data !== 32'h8000_0000) begin
          n_fail++;
          $display("FAIL bp_order: got t=%0d cnt=%0d d=%h want t=%0d cnt=%0d d=80000000",
                   a_out_tag, a_out_count, a_out_data, exp_tag, 28 - exp_tag);
        end
        exp_tag++;
      end
      if (a_in_valid && a_in_ready) next_tag++;
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    n_tests++;
    if (exp_tag != 7 || saw_block !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_summary: delivered=%0d blocked=%b extra_valid=%b want 6 1 0",
               exp_tag - 1, saw_block, a_out_valid);
    end
  endtask

  task automatic test_random();
    exp_t qb[$];
    exp_t qc[$];
    exp_t e;
    logic b_hold = 0, c_hold = 0, b_stall = 0, c_stall = 0;
    logic [33:0] b_prev = '0;
    logic [12:0] c_prev = '0;
    int b_tag = 0, c_tag = 0;
    for (int cyc = 0; cyc < 3040; cyc++) begin
      @(negedge clk);
      if (!b_hold) begin
        b_in_valid = (cyc < 3000) && ($urandom_range(0, 3) != 0);
        b_in_data  = 24'(pick_word());
        b_in_tag   = 4'(b_tag);
      end
      if (!c_hold) begin
        c_in_valid = (cyc < 3000) && ($urandom_range(0, 3) != 0);
        c_in_data  = 5'(pick_word());
        c_in_tag   = 4'(c_tag);
      end
      b_out_ready = (cyc >= 3000) || ($urandom_range(0, 2) != 0);
      c_out_ready = (cyc >= 3000) || ($urandom_range(0, 2) != 0);
      #1;
      if (b_stall) begin
        n_tests++;
        if (b_out_valid !== 1'b1 || {b_out_count, b_out_data, b_out_zero, b_out_tag} !== b_prev) begin
          n_fail++;
          $display("FAIL rand_b_stall: got v=%b %h want v=1 %h", b_out_valid,
                   {b_out_count, b_out_data, b_out_zero, b_out_tag}, b_prev);
        end
      end
      if (c_stall) begin
        n_tests++;
        if (c_out_valid !== 1'b1 || {c_out_count, c_out_data, c_out_zero, c_out_tag} !== c_prev) begin
          n_fail++;
          $display("FAIL rand_c_stall: got v=%b %h want v=1 %h", c_out_valid,
                   {c_out_count, c_out_data, c_out_zero, c_out_tag}, c_prev);
        end
      end
      if (b_in_valid && b_in_ready) begin
        model(32'(b_in_data), 24, 1, e);
        e.tag = b_in_tag;
        qb.push_back(e);
        b_tag++;
      end
      if (c_in_valid && c_in_ready) begin
        model(32'(c_in_data), 5, 1, e);
        e.tag = c_in_tag;
        qc.push_back(e);
        c_tag++;
      end
      if (b_out_valid && b_out_ready) begin
        n_tests++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL rand_b: unexpected output t=%0d", b_out_tag);
        end else begin
          e = qb.pop_front();
          if (32'(b_out_count) !== e.cnt || 32'(b_out_data) !== e.data ||
              b_out_zero !== e.z || b_out_tag !== e.tag) begin
            n_fail++;
            $display("FAIL rand_b: got cnt=%0d d=%h z=%b t=%0d want cnt=%0d d=%h z=%b t=%0d",
                     b_out_count, b_out_data, b_out_zero, b_out_tag, e.cnt, e.data, e.z, e.tag);
          end
        end
      end
      if (c_out_valid && c_out_ready) begin
        n_tests++;
        if (qc.size() == 0) begin
          n_fail++;
          $display("FAIL rand_c: unexpected output t=%0d", c_out_tag);
        end else begin
          e = qc.pop_front();
          if (32'(c_out_count) !== e.cnt || 32'(c_out_data) !== e.data ||
              c_out_zero !== e.z || c_out_tag !== e.tag) begin
            n_fail++;
            $display("FAIL rand_c: got cnt=%0d d=%b z=%b t=%0d want cnt=%0d d=%h z=%b t=%0d",
                     c_out_count, c_out_data, c_out_zero, c_out_tag, e.cnt, e.data, e.z, e.tag);
          end
        end
      end
      b_hold  = b_in_valid && !b_in_ready;
      c_hold  = c_in_valid && !c_in_ready;
      b_stall = b_out_valid && !b_out_ready;
      c_stall = c_out_valid && !c_out_ready;
      b_prev  = {b_out_count, b_out_data, b_out_zero, b_out_tag};
      c_prev  = {c_out_count, c_out_data, c_out_zero, c_out_tag};
    end
    n_tests++;
    if (qb.size() != 0 || qc.size() != 0 || b_in_valid || c_in_valid) begin
      n_fail++;
      $display("FAIL rand_drain: left b=%0d c=%0d pending b=%b c=%b want 0 0 0 0",
               qb.size(), qc.size(), b_in_valid, c_in_valid);
    end
  endtask

  task automatic test_async_reset();
    logic seen = 1'b0;
    @(negedge clk);
    b_out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 24'hFFF000;
      b_in_tag   = 4'(i);
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    #1;
    n_tests++;
    if (b_out_valid !== 1'b1 || b_out_tag !== 4'd1) begin
      n_fail++;
      $display("FAIL arst_prefill: got v=%b t=%0d want v=1 t=1", b_out_valid, b_out_tag);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (b_out_valid !== 1'b0 || b_out_tag !== 4'd0 || b_out_data !== '0 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: got b v=%b t=%0d d=%h a v=%b want 0 0 0 0",
               b_out_valid, b_out_tag, b_out_data, a_out_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_release: got ready=%b v=%b want 1 0", b_in_ready, b_out_valid);
    end
    @(negedge clk);
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = 24'h000001;
    b_in_tag    = 4'd9;
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      if (b_out_valid) begin
        seen = 1'b1;
        n_tests++;
        if (b_out_tag !== 4'd9 || b_out_count !== 5'd22 || b_out_data !== 24'h400000) begin
          n_fail++;
          $display("FAIL arst_first: got t=%0d cnt=%0d d=%h want t=9 cnt=22 d=400000",
                   b_out_tag, b_out_count, b_out_data);
        end
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL arst_timeout: no output within 10 cycles, want tag 9");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_s0();
    test_mode1();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
